shift16_issue_ctrl: RTL and testbench
=====================================

Name: shift16_issue_ctrl

Overview:
- Flow-control stage wrapped around the fixed-latency shift16 pipeline (2-cycle, non-stallable, no reset).
- Accepts shift requests on a valid/ready input and drives shift16's a/distance.
- Tracks in-flight requests with a valid shift register and captures shift16's r into a small result FIFO, presented on a valid/ready output.
- Credit-based back-pressure: results are never lost, even though shift16 itself cannot stall.

Parameters:
- WIDTH, 16, data width of a/r.
- DIST_W, 4, width of distance.
- LATENCY, 2, shift16 cycles from operand sample to r valid; must match shift16.
- DEPTH, 4, result FIFO entries; power of two, must be >= LATENCY+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid&in_ready at clk edge
- in_a  in  WIDTH  operand
- in_distance  in  DIST_W  left-shift distance
- sh_a  out  WIDTH  to shift16 a; combinational copy of in_a
- sh_distance  out  DIST_W  to shift16 distance; combinational copy of in_distance
- sh_r  in  WIDTH  from shift16 r
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid&out_ready at clk edge
- out_data  out  WIDTH  FIFO head

Behaviour:
- Reset values: in_ready=1 (credits full), out_valid=0, out_data=0, vpipe=0, FIFO pointers/count=0. FIFO storage is not reset.
- Accept: fire_in = in_valid & in_ready. Operands pass straight through, so shift16 samples them at the same edge.
- vpipe[LATENCY-1:0]:
  - vpipe[0] <= fire_in
  - vpipe[i] <= vpipe[i-1]
  - When vpipe[LATENCY-1]=1, sh_r holds the result of the request accepted LATENCY-1 edges earlier; it is written to the FIFO at the next edge.
  - Total latency: accept at edge E0 -> out_valid high after edge E0+LATENCY (visible cycle after E2 for the default).
- Credits:
  - occupied = fifo_count + popcount(vpipe).
  - in_ready = (occupied < DEPTH); a function of registered state only, with no combinational path from in_valid or out_ready.
  - A pop frees its credit from the following cycle.
- FIFO:
  - Push when vpipe[LATENCY-1]; pop when out_valid & out_ready.
  - Simultaneous push+pop: count unchanged; both pointers advance; data ordering preserved.
  - Push+pop with count=1: new head appears next cycle with no bubble.
  - Push into an empty FIFO: no bypass; out_valid rises the cycle after the write edge.
  - Overflow is impossible by construction. Include an assertion: no push when count==DEPTH.
  - Pop when empty is ignored; out_valid=0 gates it.
- Ordering: strict FIFO; output order equals acceptance order.
- Throughput: 1 result/cycle sustained with out_ready held high (needs DEPTH >= LATENCY+1).
- Reset mid-operation: vpipe cleared, so in-flight shift16 results are discarded and never pushed; FIFO emptied; in_ready=1 in the first cycle after reset deassertion.
- Pointers: log2(DEPTH) bits with natural wrap. Count is log2(DEPTH)+1 bits.
- in_distance is passed unmodified; shift16 defines the shift semantics (a << distance, truncated to WIDTH).

Decomposition:
- Package shift_pkg: localparams WIDTH=16, DIST_W=4, SHIFT_LATENCY=2; typedefs word_t logic[WIDTH-1:0] and dist_t logic[DIST_W-1:0]. shift16 and this block both import it.
- One sub-module: shift_result_fifo (synchronous FIFO: push/pop/data/count/empty/full, async active-high rst).
- Credit and vpipe logic stay in the top.
- Bench instantiates shift16_issue_ctrl together with shift16.

Test Plan:
- Single request a=16'h0001, distance=5, out_ready=1 -> out_data=16'h0020, out_valid for exactly 1 cycle, rising 2 edges after accept.
- Streaming: 50 back-to-back requests a=1, distance=0..15 wrapping, out_ready=1 -> in_ready never drops; results 1<<d in order; one result per cycle after initial latency.
- Back-pressure: out_ready=0, in_valid held -> exactly 4 accepts, then in_ready=0; raise out_ready -> 4 results in order; in_ready re-asserts the cycle after the first pop.
- Simultaneous push+pop at count=1 (out_ready=1, steady stream) -> count stays 1; no bubble or duplicate on out_data.
- Truncation: a=16'h8001, distance=15 -> 16'h8000; a=16'hFFFF, distance=4 -> 16'hFFF0.
- Reset mid-flight: accept 2 requests, assert rst the next cycle -> out_valid stays 0 after release (no stale push), in_ready=1, and a subsequent a=3, distance=2 yields 16'h000C.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, latency and word types for shift16 and its issue control
package shift_pkg;
    localparam int WIDTH         = 16;
    localparam int DIST_W        = 4;
    localparam int SHIFT_LATENCY = 2;
    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [DIST_W-1:0] dist_t;
endpackage

// File: rtl/shift16.sv
// shift16: fixed two-cycle left shifter, non-stallable, no reset
module shift16 import shift_pkg::*; (
    input  logic  clk,
    input  word_t a,
    input  dist_t distance,
    output word_t r
);
    word_t a_q, r_q;
    dist_t dist_q;
    word_t r_d;
    // shift result computed from the sampled operands
    always_comb r_d = a_q << dist_q;
    // stage 1 samples operands, stage 2 holds the truncated result
    always_ff @(posedge clk) begin
        a_q    <= a;
        dist_q <= distance;
        r_q    <= r_d;
    end
    assign r = r_q;
endmodule

// File: rtl/shift_result_fifo.sv
// shift_result_fifo: synchronous FIFO holding shift results; storage itself is not reset
module shift_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;
    // pointer/count next state; a pop on empty is dropped
    always_comb begin
        do_pop  = pop & ~empty;
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end
    // pointers and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    // storage write
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data;
    end
    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/shift16_issue_ctrl.sv
// shift16_issue_ctrl: credit-based valid/ready wrapper around the non-stallable shift16 pipeline
module shift16_issue_ctrl #(
    parameter int WIDTH   = shift_pkg::WIDTH,
    parameter int DIST_W  = shift_pkg::DIST_W,
    parameter int LATENCY = shift_pkg::SHIFT_LATENCY,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [DIST_W-1:0] in_distance,
    output logic [WIDTH-1:0]  sh_a,
    output logic [DIST_W-1:0] sh_distance,
    input  logic [WIDTH-1:0]  sh_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
);
    localparam int OCC_W = $clog2(DEPTH + LATENCY + 1);
    logic [LATENCY-1:0]     vpipe_q, vpipe_d;
    logic [$clog2(DEPTH):0] count;
    logic [OCC_W-1:0]       occupied;
    logic                   fire_in, push, pop, empty, full;
    assign sh_a        = in_a;
    assign sh_distance = in_distance;
    // every accepted request reserves a FIFO slot until it is popped, so shift16 never needs to stall
    always_comb begin
        occupied = OCC_W'(count);
        for (int i = 0; i < LATENCY; i++) occupied = occupied + OCC_W'(vpipe_q[i]);
        in_ready = (occupied < OCC_W'(DEPTH));
        fire_in  = in_valid & in_ready;
        vpipe_d  = (vpipe_q << 1) | LATENCY'(fire_in);
        push     = vpipe_q[LATENCY-1];
        pop      = out_valid & out_ready;
    end
    // in-flight tracker; clearing it on reset discards results still inside shift16
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vpipe_q <= '0;
        else     vpipe_q <= vpipe_d;
    end
    shift_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sh_r),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );
    assign out_valid = ~empty;
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: tb/tb_shift16_issue_ctrl.sv
// tb_shift16_issue_ctrl: directed checks of shift16_issue_ctrl wrapped around shift16
module tb_shift16_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [3:0]  in_distance = '0;
    logic [15:0] sh_a;
    logic [3:0]  sh_distance;
    logic [15:0] sh_r;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    shift16_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_distance (in_distance),
        .sh_a        (sh_a),
        .sh_distance (sh_distance),
        .sh_r        (sh_r),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    shift16 u_sh (
        .clk      (clk),
        .a        (sh_a),
        .distance (sh_distance),
        .r        (sh_r)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick;
        tick;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        tick;

        // single request: 1 << 5, valid for exactly one cycle two edges after accept
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h0001; in_distance = 4'd5;
        chk("single_passthru", {12'h0, sh_distance, sh_a}, 32'h0005_0001);
        tick;
        in_valid = 1'b0;
        chk("single_e0", 32'(out_valid), 32'h0);
        tick;
        chk("single_e1", 32'(out_valid), 32'h0);
        tick;
        chk("single_e2", {15'h0, out_valid, out_data}, 32'h0001_0020);
        tick;
        chk("single_e3", 32'(out_valid), 32'h0);

        // truncation, back to back; second result replaces the first with no bubble
        in_valid = 1'b1; in_a = 16'h8001; in_distance = 4'd15;
        tick;
        in_a = 16'hFFFF; in_distance = 4'd4;
        tick;
        in_valid = 1'b0;
        tick;
        chk("trunc_8001", {15'h0, out_valid, out_data}, 32'h0001_8000);
        tick;
        chk("trunc_ffff", {15'h0, out_valid, out_data}, 32'h0001_FFF0);
        tick;
        chk("trunc_drain", 32'(out_valid), 32'h0);

        // streaming 50 requests, one result per cycle in order
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1; in_a = 16'h0001; in_distance = 4'(i % 16);
            chk("stream_ready", 32'(in_ready), 32'h1);
            tick;
            if (i >= 2) chk("stream_data", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'(1 << ((i - 2) % 16))});
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick;
            chk("stream_tail", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'(1 << ((48 + j) % 16))});
        end
        tick;
        chk("stream_drain", 32'(out_valid), 32'h0);

        // back-pressure: four credits, then stall until the first pop
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h0001;
        for (int c = 0; c < 8; c++) begin
            in_distance = 4'(c);
            chk("bp_ready", 32'(in_ready), {31'h0, c < 4});
            tick;
        end
        chk("bp_full_valid", {15'h0, out_valid, out_data}, 32'h0001_0001);
        out_ready = 1'b1;
        chk("bp_ready_before_pop", 32'(in_ready), 32'h0);
        tick;
        chk("bp_ready_after_pop", 32'(in_ready), 32'h1);
        chk("bp_data1", {15'h0, out_valid, out_data}, 32'h0001_0002);
        in_valid = 1'b0;
        tick;
        chk("bp_data2", {15'h0, out_valid, out_data}, 32'h0001_0004);
        tick;
        chk("bp_data3", {15'h0, out_valid, out_data}, 32'h0001_0008);
        tick;
        chk("bp_drain", 32'(out_valid), 32'h0);

        // reset with two requests in flight: nothing stale may surface
        in_valid = 1'b1; in_a = 16'h0001; in_distance = 4'd1;
        tick;
        in_distance = 4'd2;
        tick;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'h1);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("midrst_no_stale", 32'(out_valid), 32'h0);
        end
        chk("postrst_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1; in_a = 16'h0003; in_distance = 4'd2;
        tick;
        in_valid = 1'b0;
        tick;
        chk("postrst_e1", 32'(out_valid), 32'h0);
        tick;
        chk("postrst_data", {15'h0, out_valid, out_data}, 32'h0001_000C);
        tick;
        chk("postrst_drain", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
